// File: rtl/cpu_trace_pkg.sv
// rtl/cpu_trace_pkg.sv - shared types for the CPU instruction-trace recorder
package cpu_trace_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    POST   = 3'd2,
    FROZEN = 3'd3,
    DRAIN  = 3'd4
  } trace_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  opc;
    logic [63:0] ula;
    logic [15:0] stamp;
  } trace_entry_t;

  localparam int ENTRY_W = 151;
  localparam logic [15:0] CYC_MAX = 16'hFFFF;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - trace entry storage, synchronous write, asynchronous read
module trace_ram
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - circular instruction-trace recorder with trigger/limit freeze and drain port
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int          DEPTH         = 16,
  parameter logic [2:0]  CAPTURE_STATE = 3'd0,
  parameter int          POST_COUNT    = 8,
  parameter int          CYCLE_LIMIT   = 30
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   trig_en,
  input  logic [63:0]            trig_pc,
  input  logic [63:0]            pc,
  input  logic [31:0]            opcode,
  input  logic [2:0]             stt,
  input  logic [63:0]            ula_out,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [63:0]            rd_pc,
  output logic [6:0]             rd_opcode,
  output logic [63:0]            rd_ula,
  output logic [15:0]            rd_stamp,
  output logic [2:0]             trace_state,
  output logic                   frozen,
  output logic                   timeout,
  output logic [$clog2(DEPTH):0] entry_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_COUNT);
  localparam logic [AW-1:0] POST_ONE  = AW'(1);
  localparam logic [15:0]   LIMIT_M1  = 16'(CYCLE_LIMIT - 1);

  trace_state_e  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, post_q;
  logic [CW-1:0] cnt_q, rem_q;
  logic [15:0]   cyc_q;
  logic [2:0]    stt_q;
  logic          wrapped_q, timeout_q, first_q;
  logic          recording, start, capture, hit, limit, xfer;
  trace_entry_t  wr_entry, rd_entry;
  logic          opcode_unused;

  assign opcode_unused = ^opcode[31:7];

  assign recording = (state_q == ARMED) || (state_q == POST);
  // arm is only honoured before the trace is frozen; a restart suppresses capture that cycle
  assign start   = arm && ((state_q == IDLE) || (state_q == ARMED));
  assign capture = recording && !start && (stt == CAPTURE_STATE) &&
                   ((stt_q != CAPTURE_STATE) || first_q);
  assign hit     = trig_en && (pc == trig_pc);
  assign limit   = recording && !start && (cyc_q == LIMIT_M1);
  assign rd_valid = (state_q == DRAIN) && (rem_q != '0);
  assign xfer    = rd_valid && rd_ready;

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = ARMED;
      ARMED: begin
        if (start)              state_d = ARMED;
        else if (limit)         state_d = FROZEN;
        else if (capture && hit) state_d = (POST_COUNT == 0) ? FROZEN : POST;
      end
      POST:   if (limit || (capture && post_q == POST_ONE)) state_d = FROZEN;
      FROZEN: state_d = (cnt_q == '0) ? IDLE : DRAIN;
      DRAIN:  if (xfer && rem_q == ONE_C) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      post_q    <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      cyc_q     <= '0;
      stt_q     <= '0;
      wrapped_q <= 1'b0;
      timeout_q <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      stt_q <= stt;
      if (start) begin
        wr_ptr_q  <= '0;
        cnt_q     <= '0;
        wrapped_q <= 1'b0;
        timeout_q <= 1'b0;
        cyc_q     <= '0;
        first_q   <= 1'b1;
      end else begin
        if (state_q == ARMED) first_q <= 1'b0;
        if (recording && cyc_q != CYC_MAX) cyc_q <= cyc_q + 16'd1;
        if (capture) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          if (cnt_q == FULL) wrapped_q <= 1'b1;
          else               cnt_q     <= cnt_q + 1'b1;
        end
        if (limit) timeout_q <= 1'b1;
        if (state_q == ARMED && capture && hit) post_q <= POST_INIT;
        else if (state_q == POST && capture)    post_q <= post_q - 1'b1;
        // after a wrap the oldest surviving entry sits at the write pointer
        if (state_q == FROZEN) begin
          rd_ptr_q <= wrapped_q ? wr_ptr_q : '0;
          rem_q    <= cnt_q;
        end
        if (xfer) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          rem_q    <= rem_q - 1'b1;
        end
      end
    end
  end

  assign wr_entry.pc    = pc;
  assign wr_entry.opc   = opcode[6:0];
  assign wr_entry.ula   = ula_out;
  assign wr_entry.stamp = cyc_q;

  trace_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock (clock),
    .we    (capture),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // RAM is never reset, so the read fields are masked outside a valid beat
  assign rd_pc       = rd_valid ? rd_entry.pc    : '0;
  assign rd_opcode   = rd_valid ? rd_entry.opc   : '0;
  assign rd_ula      = rd_valid ? rd_entry.ula   : '0;
  assign rd_stamp    = rd_valid ? rd_entry.stamp : '0;
  assign trace_state = state_q;
  assign frozen      = (state_q == FROZEN) || (state_q == DRAIN);
  assign timeout     = timeout_q;
  assign entry_count = cnt_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - scoreboard bench for cpu_trace_buffer against a queue-based trace model
module tb_cpu_trace_buffer;

  localparam int DEPTH = 16;
  localparam int NDUT  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic        trig_en = 1'b0;
  logic        rd_ready = 1'b0;
  logic [63:0] trig_pc = '0;
  logic [63:0] pc = '0;
  logic [63:0] ula_out = '0;
  logic [31:0] opcode = '0;
  logic [2:0]  stt = '0;
  int          sel = 0;

  logic        rv   [NDUT];
  logic        rdy  [NDUT];
  logic [63:0] rpc  [NDUT];
  logic [63:0] rula [NDUT];
  logic [6:0]  ropc [NDUT];
  logic [15:0] rstm [NDUT];
  logic [2:0]  tst  [NDUT];
  logic        frz  [NDUT];
  logic        tmo  [NDUT];
  logic [4:0]  ecnt [NDUT];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign rdy[g] = (sel == g) ? rd_ready : 1'b1;
    cpu_trace_buffer #(
      .DEPTH(DEPTH), .CAPTURE_STATE(3'd0),
      .POST_COUNT(g == 0 ? 0 : (g == 1 ? 2 : 8)),
      .CYCLE_LIMIT(g == 2 ? 30 : 1000)
    ) u_dut (
      .clock(clock), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
      .pc(pc), .opcode(opcode), .stt(stt), .ula_out(ula_out),
      .rd_valid(rv[g]), .rd_ready(rdy[g]), .rd_pc(rpc[g]), .rd_opcode(ropc[g]),
      .rd_ula(rula[g]), .rd_stamp(rstm[g]), .trace_state(tst[g]), .frozen(frz[g]),
      .timeout(tmo[g]), .entry_count(ecnt[g])
    );
  end

  logic        rd_valid_s, frozen_s, timeout_s;
  logic [63:0] rd_pc_s, rd_ula_s;
  logic [6:0]  rd_opc_s;
  logic [15:0] rd_stamp_s;
  logic [2:0]  state_s;
  logic [4:0]  count_s;
  assign rd_valid_s = rv[sel];
  assign rd_pc_s    = rpc[sel];
  assign rd_ula_s   = rula[sel];
  assign rd_opc_s   = ropc[sel];
  assign rd_stamp_s = rstm[sel];
  assign state_s    = tst[sel];
  assign frozen_s   = frz[sel];
  assign timeout_s  = tmo[sel];
  assign count_s    = ecnt[sel];

  typedef struct {
    logic [63:0] pc;
    logic [6:0]  opc;
    logic [63:0] ula;
    logic [15:0] stamp;
  } exp_t;

  exp_t     exp_q[$];
  exp_t     mon_e;
  int       cmp_cnt = 0;
  int       err_cnt = 0;
  bit       rec, post_mode, done, exp_tmo;
  int       k, post_left;
  logic [2:0] prev_stt;

  function automatic int post_of(int s);
    return (s == 0) ? 0 : ((s == 1) ? 2 : 8);
  endfunction

  function automatic int lim_of(int s);
    return (s == 2) ? 30 : 1000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every accepted read beat must match the oldest outstanding model entry.
  always @(negedge clock) begin
    if (rd_valid_s && rd_ready) begin
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL unexpected_entry: actual pc %0h required none", rd_pc_s);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_pc", rd_pc_s, mon_e.pc);
        chk("rd_opcode", 64'(rd_opc_s), 64'(mon_e.opc));
        chk("rd_ula", rd_ula_s, mon_e.ula);
        chk("rd_stamp", 64'(rd_stamp_s), 64'(mon_e.stamp));
      end
    end
  end

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    arm = 1'b0;
    rd_ready = 1'b0;
    repeat (cycles) tick();
    reset = 1'b1;
    prev_stt = 3'd0;
    rec = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    stt = 3'd1;
    tick();
    arm = 1'b0;
    prev_stt = 3'd1;
    rec = 1'b1;
    k = 0;
    post_mode = 1'b0;
    done = 1'b0;
    exp_tmo = 1'b0;
    exp_q.delete();
  endtask

  // One clock of CPU activity; the model applies the recording rules to it.
  task automatic step(input logic [63:0] p, input logic [31:0] op, input logic [63:0] u,
                      input logic [2:0] s);
    exp_t e;
    pc = p;
    opcode = op;
    ula_out = u;
    stt = s;
    if (rec) begin
      if (s == 3'd0 && (prev_stt != 3'd0 || k == 0)) begin
        e.pc = p;
        e.opc = op[6:0];
        e.ula = u;
        e.stamp = 16'(k);
        exp_q.push_back(e);
        if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
        if (post_mode) begin
          post_left--;
          if (post_left == 0) done = 1'b1;
        end else if (trig_en && p == trig_pc) begin
          if (post_of(sel) == 0) done = 1'b1;
          else begin
            post_mode = 1'b1;
            post_left = post_of(sel);
          end
        end
      end
      if (k == lim_of(sel) - 1) begin
        done = 1'b1;
        exp_tmo = 1'b1;
      end
      k++;
      if (done) rec = 1'b0;
    end
    prev_stt = s;
    tick();
  endtask

  // Instructions at pc0+4*i; len 0 picks a random 2..4 cycle length per instruction.
  task automatic run_instrs(input int n, input logic [63:0] pc0, input int len, input int first_len);
    int li;
    logic [31:0] op;
    logic [63:0] u;
    for (int i = 0; i < n && !done; i++) begin
      li = (i == 0 && first_len > 0) ? first_len : ((len > 0) ? len : int'($urandom_range(2, 4)));
      op = $urandom;
      u = {$urandom, $urandom};
      for (int j = 0; j < li && !done; j++)
        step(pc0 + 64'(4 * i), op, u, (j == 0) ? 3'd0 : 3'($urandom_range(1, 7)));
    end
  endtask

  task automatic chk_frozen(input string name, input int exp_cnt);
    chk({name, "_state"}, 64'(state_s), 64'd3);
    chk({name, "_frozen"}, 64'(frozen_s), 64'd1);
    chk({name, "_count"}, 64'(count_s), 64'(exp_cnt));
    chk({name, "_timeout"}, 64'(timeout_s), 64'(exp_tmo));
  endtask

  task automatic drain(input string name, input int random_ready);
    int guard = 0;
    while ((exp_q.size() != 0 || rd_valid_s) && guard < 400) begin
      rd_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      guard++;
    end
    rd_ready = 1'b0;
    chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_idle"}, 64'(state_s), 64'd0);
    chk({name, "_valid_low"}, 64'(rd_valid_s), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    // reset held with arm asserted and stt toggling
    sel = 0;
    reset = 1'b0;
    arm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stt = 3'(i & 1);
      tick();
      chk("rst_state", 64'(state_s), 64'd0);
      chk("rst_valid", 64'(rd_valid_s), 64'd0);
      chk("rst_count", 64'(count_s), 64'd0);
      chk("rst_flags", {62'd0, frozen_s, timeout_s}, 64'd0);
      chk("rst_rd_pc", rd_pc_s, 64'd0);
    end
    arm = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stt = 3'(i & 1);
      tick();
    end
    chk("post_rst_state", 64'(state_s), 64'd0);
    chk("post_rst_count", 64'(count_s), 64'd0);

    // five instructions, trigger on the last, no post-count
    do_reset(2);
    sel = 0;
    trig_en = 1'b1;
    trig_pc = 64'd16;
    do_arm();
    run_instrs(5, 64'd0, 3, 0);
    chk_frozen("t2", 5);
    drain("t2", 0);
    chk("t2_timeout_hold", 64'(timeout_s), 64'd0);

    // wrap: 20 instructions, oldest four overwritten
    do_reset(2);
    sel = 0;
    trig_pc = 64'd76;
    do_arm();
    run_instrs(20, 64'd0, 0, 0);
    chk_frozen("t3", 16);
    drain("t3", 1);

    // post-count of two, with a mid-drain stall
    do_reset(2);
    sel = 1;
    trig_pc = 64'd8;
    do_arm();
    run_instrs(10, 64'd0, 0, 0);
    chk_frozen("t4", 5);
    rd_ready = 1'b0;
    tick();
    rd_ready = 1'b1;
    tick();
    tick();
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_valid", 64'(rd_valid_s), 64'd1);
      chk("t4_stall_pc", rd_pc_s, (exp_q.size() != 0) ? exp_q[0].pc : 64'hDEAD);
      tick();
    end
    drain("t4", 0);

    // cycle limit with no trigger
    do_reset(2);
    sel = 2;
    trig_en = 1'b0;
    do_arm();
    run_instrs(40, 64'h1000, 0, 0);
    chk_frozen("t5a", exp_q.size());
    chk("t5a_timeout", 64'(timeout_s), 64'd1);
    drain("t5a", 1);
    chk("t5a_timeout_hold", 64'(timeout_s), 64'd1);

    // trigger landing on the limit cycle
    do_reset(2);
    sel = 2;
    trig_en = 1'b1;
    trig_pc = 64'h2000 + 64'd56;
    do_arm();
    run_instrs(40, 64'h2000, 2, 3);
    chk_frozen("t5b", 15);
    chk("t5b_timeout", 64'(timeout_s), 64'd1);
    drain("t5b", 0);

    // reset during drain, then a clean re-record
    do_reset(2);
    sel = 0;
    trig_pc = 64'h316;
    do_arm();
    run_instrs(5, 64'h306, 0, 0);
    chk_frozen("t6a", 5);
    rd_ready = 1'b1;
    tick();
    tick();
    tick();
    rd_ready = 1'b0;
    reset = 1'b0;
    tick();
    chk("t6_state", 64'(state_s), 64'd0);
    chk("t6_valid", 64'(rd_valid_s), 64'd0);
    chk("t6_count", 64'(count_s), 64'd0);
    chk("t6_frozen", 64'(frozen_s), 64'd0);
    reset = 1'b1;
    exp_q.delete();
    prev_stt = 3'd0;
    trig_pc = 64'h50;
    do_arm();
    run_instrs(8, 64'h40, 0, 0);
    chk_frozen("t6b", 5);
    drain("t6b", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Synthesizable instruction-trace recorder downstream of the multicycle CPU. It consumes the CPU debug outputs (PC, opcode, FSM state, ALU result) and records one entry per instruction into a circular buffer. Recording stops on a PC trigger plus post-count, or on a cycle limit; this is the hardware counterpart of the bench's `$monitor`/`$stop`. The frozen trace then drains through a valid/ready read port.

Parameters:
DEPTH, 16, number of entries (power of 2, ≥2)
CAPTURE_STATE, 3'd0, CPU FSM state whose entry marks a new instruction (fetch)
POST_COUNT, 8, captures after the trigger entry before freezing (0..DEPTH-1)
CYCLE_LIMIT, 30, clocks after arm before forced freeze (1..65535)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-low reset
arm  in  1  one-cycle pulse: start recording
trig_en  in  1  enable PC trigger
trig_pc  in  64  trigger PC
pc  in  64  CPU Pc_Out
opcode  in  32  CPU instruction; only [6:0] stored
stt  in  3  CPU FSM state (STT)
ula_out  in  64  CPU ULA_Out
rd_valid  out  1  read entry available
rd_ready  in  1  consumer accepts entry
rd_pc  out  64  entry PC
rd_opcode  out  7  entry opcode[6:0]
rd_ula  out  64  entry ALU result
rd_stamp  out  16  cycle stamp of entry
trace_state  out  3  current FSM state encoding
frozen  out  1  high in FROZEN and DRAIN
timeout  out  1  freeze was caused by CYCLE_LIMIT
entry_count  out  $clog2(DEPTH)+1  valid entries held

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE. All outputs 0. Pointers, counters, flags and stt_q cleared. RAM contents are not reset.
- Capture event: state in {ARMED, POST} and stt==CAPTURE_STATE and (stt_q!=CAPTURE_STATE or first_q). first_q is set on arm and cleared after the first ARMED cycle.
- The entry {pc, opcode[6:0], ula_out, cyc} is written at wr_ptr on the same edge. wr_ptr increments mod DEPTH. entry_count saturates at DEPTH. A write while entry_count==DEPTH overwrites the oldest entry and sets wrapped.
- cyc: 16-bit counter, cleared on arm, +1 per clock in ARMED/POST, saturates at 0xFFFF.
- IDLE: arm → ARMED. Clears wr_ptr, entry_count, wrapped, timeout and cyc.
- ARMED:
  - arm restarts (same clearing as from IDLE).
  - Capture with trig_en and pc==trig_pc → POST with post_cnt=POST_COUNT; the trigger entry is written. If POST_COUNT==0, go to FROZEN instead.
- POST: each capture decrements post_cnt; the capture that reaches 0 → FROZEN. arm is ignored.
- Cycle limit: cyc reaching CYCLE_LIMIT-1 in ARMED/POST → FROZEN, timeout=1.
  - If limit and trigger/last capture coincide, the capture is written, the next state is FROZEN, and timeout=1.
- FROZEN (exactly 1 cycle): no writes. rd_ptr = wrapped ? wr_ptr : 0; remaining = entry_count. Then → DRAIN, or → IDLE if remaining==0.
- DRAIN:
  - rd_valid = (remaining!=0); rd_* = RAM[rd_ptr].
  - Transfer on rd_valid && rd_ready: rd_ptr++ mod DEPTH, remaining--.
  - rd_* and rd_valid stay stable while rd_ready is low.
  - The final transfer → IDLE. rd_valid drops the following cycle; timeout holds until the next arm.
- arm is ignored in FROZEN/DRAIN. stt_q registers stt every cycle.
- Latency: entry written at the edge where the capture condition is true. frozen rises 1 cycle after the last write. First rd_valid occurs 2 cycles after the last write.
- PC compare is a full 64-bit equality compare. Stamps are unsigned.

Decomposition:
- cpu_trace_pkg:
  - trace_state_e: IDLE=0, ARMED=1, POST=2, FROZEN=3, DRAIN=4
  - trace_entry_t struct {pc[63:0], opc[6:0], ula[63:0], stamp[15:0]}
  - ENTRY_W=151
- Sub-module trace_ram: DEPTH×ENTRY_W, synchronous write, asynchronous read, no reset.

Test Plan:
1. reset low 3 clocks with arm=1, stt toggling → stays IDLE, all outputs 0, no entries after release.
2. CYCLE_LIMIT=1000, arm, 5 instructions at pc 0,4,8,12,16 (stt 0→1→2→0…), trig_en=1 with trig_pc=16, POST_COUNT=0 → FROZEN after pc=16 write, entry_count=5; drain with rd_ready=1 returns pc 0,4,8,12,16 in order, timeout=0.
3. DEPTH=16, 20 instructions pc=4*i, trigger on pc=76, POST_COUNT=0 → wrapped, entry_count=16; drain returns pc 16..76 oldest first.
4. Trigger at pc=8, POST_COUNT=2 → last entry pc=16, count=5; rd_ready low 3 cycles mid-drain → rd_pc held, no loss or duplication.
5. CYCLE_LIMIT=30, no trigger → freeze at cyc=29, timeout=1; rd_stamp values increase monotonically; coincident trigger at cyc=29 still sets timeout=1.
6. reset low during DRAIN → IDLE next cycle, rd_valid=0, entry_count=0; arm re-records cleanly.
